// File: rtl/fc_seq_ctrl_pkg.sv
// Shared encodings for the FC sequencing controller: commands, buffer selects,
// FSM state codes and default widths.
package fc_seq_ctrl_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefSizeW = 21;
  localparam int unsigned DefAddrW = 14;
  localparam int unsigned DefIdxW  = 4;

  localparam logic [2:0] CmdIdle  = 3'd0;
  localparam logic [2:0] CmdLoadF = 3'd1;
  localparam logic [2:0] CmdLoadB = 3'd2;
  localparam logic [2:0] CmdLoadW = 3'd3;

  localparam logic [1:0] SelFeat   = 2'd1;
  localparam logic [1:0] SelBias   = 2'd2;
  localparam logic [1:0] SelWeight = 2'd3;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StLoad     = 3'd1;
  localparam logic [2:0] StLoadDone = 3'd2;
  localparam logic [2:0] StComp     = 3'd3;
  localparam logic [2:0] StWaitAcc  = 3'd4;
  localparam logic [2:0] StDone     = 3'd5;

  // Reserved command codes behave as idle.
  function automatic logic is_load_cmd(logic [2:0] cmd);
    return (cmd == CmdLoadF) || (cmd == CmdLoadB) || (cmd == CmdLoadW);
  endfunction

endpackage

// File: rtl/fc_seq_ctrl_if.sv
// Stream, buffer-write and MAC-strobe signals between the controller and the
// FC datapath. The datapath side is the master, the controller the slave.
interface fc_seq_ctrl_if #(
  parameter int unsigned ADDR_W = 14
) ();
  logic                s_axis_tvalid;
  logic                s_axis_tlast;
  logic                s_axis_tready;
  logic                buf_we;
  logic [1:0]          buf_sel;
  logic [ADDR_W-1:0]   buf_addr;
  logic                mac_en;
  logic                mac_last;
  logic [ADDR_W-1:0]   f_raddr;
  logic [ADDR_W-1:0]   w_raddr;
  logic                acc_valid;
  logic signed [31:0]  acc_data;

  modport master (
    output s_axis_tvalid, s_axis_tlast, acc_valid, acc_data,
    input  s_axis_tready, buf_we, buf_sel, buf_addr, mac_en, mac_last, f_raddr, w_raddr
  );

  modport slave (
    input  s_axis_tvalid, s_axis_tlast, acc_valid, acc_data,
    output s_axis_tready, buf_we, buf_sel, buf_addr, mac_en, mac_last, f_raddr, w_raddr
  );
endinterface

// File: rtl/fc_seq_ctrl_argmax.sv
// Running signed maximum over row results; ties keep the earlier row index.
module fc_seq_ctrl_argmax #(
  parameter int unsigned IDX_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               upd_i,
  input  logic               first_i,
  input  logic signed [31:0] data_i,
  input  logic [IDX_W-1:0]   idx_i,
  output logic [IDX_W-1:0]   max_idx_o
);
  logic signed [31:0] max_q;
  logic [IDX_W-1:0]   idx_q;

  // First row always loads; later rows need a strictly larger value.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      max_q <= '0;
      idx_q <= '0;
    end else if (upd_i && (first_i || (data_i > max_q))) begin
      max_q <= data_i;
      idx_q <= idx_i;
    end
  end

  assign max_idx_o = idx_q;
endmodule

// File: rtl/fc_seq_ctrl.sv
// FC layer sequencer: streams load beats into the buffers, then walks the
// MAC array row by row and reports the argmax of the row results.
module fc_seq_ctrl
  import fc_seq_ctrl_pkg::*;
#(
  parameter int unsigned SIZE_W = 21,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [2:0]        command,
  input  logic [SIZE_W-1:0] size,
  input  logic              fc_start,
  fc_seq_ctrl_if.slave      bus,
  output logic              F_writedone,
  output logic              B_writedone,
  output logic              W_writedone,
  output logic              FC_DONE,
  output logic [IDX_W-1:0]  MAX_idx,
  output logic              load_err
);
  localparam int unsigned OutMax = 1 << IDX_W;

  logic [2:0]        state_q, state_d, cmd_prev_q;
  logic [1:0]        sel_q, sel_d;
  logic [SIZE_W-1:0] size_q, size_d, cnt_q, cnt_d, feat_len_q, feat_len_d, col_q, col_d;
  logic [IDX_W:0]    out_n_q, out_n_d;
  logic [IDX_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d, fdone_q, fdone_d, bdone_q, bdone_d, wdone_q, wdone_d;
  logic              fc_done_q, fc_done_d;
  logic              amax_clr, amax_upd;
  logic              tready, we, mac_en, mac_last;
  logic [ADDR_W-1:0] baddr, fra, wra;

  // Next-state and strobe decode for loads and the compute pass.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    size_d     = size_q;
    cnt_d      = cnt_q;
    feat_len_d = feat_len_q;
    out_n_d    = out_n_q;
    col_d      = col_q;
    row_d      = row_q;
    wcnt_d     = wcnt_q;
    err_d      = err_q;
    fdone_d    = fdone_q;
    bdone_d    = bdone_q;
    wdone_d    = wdone_q;
    fc_done_d  = fc_done_q;
    amax_clr   = 1'b0;
    amax_upd   = 1'b0;
    tready     = 1'b0;
    we         = 1'b0;
    mac_en     = 1'b0;
    mac_last   = 1'b0;
    baddr      = '0;
    fra        = '0;
    wra        = '0;
    case (state_q)
      StIdle: begin
        if (is_load_cmd(command) && !is_load_cmd(cmd_prev_q)) begin
          sel_d  = command[1:0];
          size_d = size;
          cnt_d  = '0;
          if (command[1:0] == SelFeat)   fdone_d = 1'b0;
          if (command[1:0] == SelBias)   bdone_d = 1'b0;
          if (command[1:0] == SelWeight) wdone_d = 1'b0;
          state_d = (size == '0) ? StLoadDone : StLoad;
        end else if (fc_start) begin
          fc_done_d = 1'b0;
          amax_clr  = 1'b1;
          row_d     = '0;
          col_d     = '0;
          wcnt_d    = '0;
          state_d   = ((feat_len_q == '0) || (out_n_q == '0)) ? StDone : StComp;
        end
      end
      StLoad: begin
        tready = 1'b1;
        baddr  = ADDR_W'(cnt_q);
        if (bus.s_axis_tvalid) begin
          we    = 1'b1;
          cnt_d = cnt_q + SIZE_W'(1);
          if ((cnt_q == size_q - SIZE_W'(1)) || bus.s_axis_tlast) begin
            if (cnt_q != size_q - SIZE_W'(1)) err_d = 1'b1;
            state_d = StLoadDone;
          end
        end
      end
      StLoadDone: begin
        if (sel_q == SelFeat) feat_len_d = cnt_q;
        if (sel_q == SelBias) begin
          out_n_d = (cnt_q >= SIZE_W'(OutMax / 4)) ? (IDX_W+1)'(OutMax) : (IDX_W+1)'(cnt_q << 2);
        end
        if (!is_load_cmd(command)) begin
          if (sel_q == SelFeat)   fdone_d = 1'b0;
          if (sel_q == SelBias)   bdone_d = 1'b0;
          if (sel_q == SelWeight) wdone_d = 1'b0;
          state_d = StIdle;
        end
      end
      StComp: begin
        mac_en = 1'b1;
        fra    = ADDR_W'(col_q);
        wra    = wcnt_q;
        wcnt_d = wcnt_q + ADDR_W'(1);
        if (col_q == feat_len_q - SIZE_W'(1)) begin
          mac_last = 1'b1;
          col_d    = '0;
          state_d  = StWaitAcc;
        end else begin
          col_d = col_q + SIZE_W'(1);
        end
      end
      StWaitAcc: begin
        if (bus.acc_valid) begin
          amax_upd = 1'b1;
          if ({1'b0, row_q} == out_n_q - (IDX_W+1)'(1)) begin
            state_d = StDone;
          end else begin
            row_d   = row_q + IDX_W'(1);
            state_d = StComp;
          end
        end
      end
      StDone: begin
        fc_done_d = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Writedone rises on the edge that enters LOAD_DONE.
    if ((state_d == StLoadDone) && (state_q != StLoadDone)) begin
      if (sel_d == SelFeat)   fdone_d = 1'b1;
      if (sel_d == SelBias)   bdone_d = 1'b1;
      if (sel_d == SelWeight) wdone_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cmd_prev_q <= CmdIdle;
      sel_q      <= '0;
      size_q     <= '0;
      cnt_q      <= '0;
      feat_len_q <= '0;
      out_n_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      wcnt_q     <= '0;
      err_q      <= 1'b0;
      fdone_q    <= 1'b0;
      bdone_q    <= 1'b0;
      wdone_q    <= 1'b0;
      fc_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_prev_q <= command;
      sel_q      <= sel_d;
      size_q     <= size_d;
      cnt_q      <= cnt_d;
      feat_len_q <= feat_len_d;
      out_n_q    <= out_n_d;
      col_q      <= col_d;
      row_q      <= row_d;
      wcnt_q     <= wcnt_d;
      err_q      <= err_d;
      fdone_q    <= fdone_d;
      bdone_q    <= bdone_d;
      wdone_q    <= wdone_d;
      fc_done_q  <= fc_done_d;
    end
  end

  fc_seq_ctrl_argmax #(
    .IDX_W (IDX_W)
  ) u_argmax (
    .clk_i     (clk),
    .rst_ni    (rstn),
    .clr_i     (amax_clr),
    .upd_i     (amax_upd),
    .first_i   (row_q == '0),
    .data_i    (bus.acc_data),
    .idx_i     (row_q),
    .max_idx_o (MAX_idx)
  );

  assign bus.s_axis_tready = tready;
  assign bus.buf_we        = we;
  assign bus.buf_sel       = sel_q;
  assign bus.buf_addr      = baddr;
  assign bus.mac_en        = mac_en;
  assign bus.mac_last      = mac_last;
  assign bus.f_raddr       = fra;
  assign bus.w_raddr       = wra;
  assign F_writedone       = fdone_q;
  assign B_writedone       = bdone_q;
  assign W_writedone       = wdone_q;
  assign FC_DONE           = fc_done_q;
  assign load_err          = err_q;
endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Randomized bench for fc_seq_ctrl against a transaction-level model of loads
// (beat counts, lengths, sticky error) and compute (address walk, argmax).
module tb_fc_seq_ctrl;
  import fc_seq_ctrl_pkg::*;

  localparam int unsigned SizeW = 21;
  localparam int unsigned AddrW = 14;
  localparam int unsigned IdxW  = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [2:0]       command = 3'd0;
  logic [SizeW-1:0] size = '0;
  logic             fc_start = 1'b0;
  logic             f_wd, b_wd, w_wd, fc_done, load_err;
  logic [IdxW-1:0]  max_idx;

  fc_seq_ctrl_if #(.ADDR_W(AddrW)) bus ();

  fc_seq_ctrl #(
    .SIZE_W (SizeW),
    .ADDR_W (AddrW),
    .IDX_W  (IdxW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .command     (command),
    .size        (size),
    .fc_start    (fc_start),
    .bus         (bus),
    .F_writedone (f_wd),
    .B_writedone (b_wd),
    .W_writedone (w_wd),
    .FC_DONE     (fc_done),
    .MAX_idx     (max_idx),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int m_feat_len = 0;
  int m_out_n = 0;
  bit m_err = 1'b0;
  int acc_tab [16];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ready"}, {31'd0, bus.s_axis_tready}, 0);
    check_val({tag, "_we"}, {31'd0, bus.buf_we}, 0);
    check_val({tag, "_mac"}, {30'd0, bus.mac_en, bus.mac_last}, 0);
    check_val({tag, "_addr"}, {18'd0, bus.buf_addr}, 0);
    check_val({tag, "_raddr"}, {4'd0, bus.f_raddr, bus.w_raddr}, 0);
    check_val({tag, "_sel"}, {30'd0, bus.buf_sel}, 0);
    check_val({tag, "_flags"}, {27'd0, f_wd, b_wd, w_wd, fc_done, load_err}, 0);
    check_val({tag, "_maxidx"}, {28'd0, max_idx}, 0);
  endtask

  task automatic clear_model();
    m_feat_len = 0;
    m_out_n    = 0;
    m_err      = 1'b0;
  endtask

  function automatic logic flag_of(input logic [2:0] cmd);
    if (cmd == CmdLoadF) return f_wd;
    if (cmd == CmdLoadB) return b_wd;
    return w_wd;
  endfunction

  // mode 0: tvalid held high, 1: toggling 1/0, 2: random
  task automatic do_load(input logic [2:0] cmd, input int sz, input int tlast_at, input int mode);
    int n, beats, cyc;
    n = (tlast_at >= 0 && tlast_at < sz) ? tlast_at + 1 : sz;
    @(negedge clk);
    command = cmd;
    size = SizeW'(sz);
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
    beats = 0;
    cyc = 0;
    while (beats < n && cyc < 200) begin
      @(negedge clk);
      if (mode == 0) bus.s_axis_tvalid = 1'b1;
      else if (mode == 1) bus.s_axis_tvalid = (cyc % 2 == 0);
      else bus.s_axis_tvalid = 1'($urandom_range(0, 1));
      bus.s_axis_tlast = bus.s_axis_tvalid && (beats == tlast_at);
      #1;
      check_val("ld_ready", {31'd0, bus.s_axis_tready}, 1);
      check_val("ld_we", {31'd0, bus.buf_we}, {31'd0, bus.s_axis_tvalid});
      if (bus.s_axis_tvalid) begin
        check_val("ld_addr", {18'd0, bus.buf_addr}, beats);
        check_val("ld_sel", {30'd0, bus.buf_sel}, {30'd0, cmd[1:0]});
        beats++;
      end
      cyc++;
    end
    if (beats < n) check_val("ld_timeout", beats, n);
    if (tlast_at >= 0 && tlast_at < sz - 1) m_err = 1'b1;
    @(negedge clk);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast = 1'b0;
    #1;
    check_val("ld_end_ready", {31'd0, bus.s_axis_tready}, 0);
    check_val("ld_end_we", {31'd0, bus.buf_we}, 0);
    check_val("ld_wdone", {31'd0, flag_of(cmd)}, 1);
    check_val("ld_err", {31'd0, load_err}, {31'd0, m_err});
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    command = CmdIdle;
    @(negedge clk);
    #1;
    check_val("ld_wdone_clr", {31'd0, flag_of(cmd)}, 0);
    if (cmd == CmdLoadF) m_feat_len = n;
    if (cmd == CmdLoadB) m_out_n = (4 * n > 16) ? 16 : 4 * n;
  endtask

  task automatic do_compute(input string tag);
    int fl, on, row, col, wexp, delay, cyc, best, exp_idx, n_mac;
    bit in_row, got_done;
    fl = m_feat_len;
    on = m_out_n;
    exp_idx = 0;
    if (fl > 0 && on > 0) begin
      best = acc_tab[0];
      for (int r = 1; r < on; r++) begin
        if (acc_tab[r] > best) begin
          best = acc_tab[r];
          exp_idx = r;
        end
      end
    end
    @(negedge clk);
    fc_start = 1'b1;
    row = 0;
    col = 0;
    wexp = 0;
    n_mac = 0;
    in_row = (fl > 0 && on > 0);
    delay = $urandom_range(0, 2);
    got_done = 1'b0;
    cyc = 0;
    while (!got_done && cyc < 1000) begin
      @(negedge clk);
      fc_start = 1'b0;
      bus.acc_valid = 1'b0;
      bus.acc_data = '0;
      if (in_row) begin
        // Spurious result during COMP must be ignored.
        if ($urandom_range(0, 3) == 0) begin
          bus.acc_valid = 1'b1;
          bus.acc_data = 32'sh7fff_ffff;
        end
        #1;
        check_val({tag, "_mac_en"}, {31'd0, bus.mac_en}, 1);
        check_val({tag, "_fra"}, {18'd0, bus.f_raddr}, col);
        check_val({tag, "_wra"}, {18'd0, bus.w_raddr}, wexp);
        check_val({tag, "_last"}, {31'd0, bus.mac_last}, (col == fl - 1) ? 1 : 0);
        wexp++;
        n_mac++;
        if (col == fl - 1) begin
          col = 0;
          in_row = 1'b0;
          delay = $urandom_range(0, 2);
        end else begin
          col++;
        end
      end else if (row < on && fl > 0) begin
        if (delay == 0) begin
          bus.acc_valid = 1'b1;
          bus.acc_data = acc_tab[row];
          row++;
          in_row = (row < on);
        end else begin
          delay--;
        end
        #1;
        check_val({tag, "_wait_mac"}, {31'd0, bus.mac_en}, 0);
      end else begin
        #1;
        check_val({tag, "_tail_mac"}, {31'd0, bus.mac_en}, 0);
        got_done = fc_done;
      end
      cyc++;
    end
    check_val({tag, "_done"}, {31'd0, fc_done}, 1);
    check_val({tag, "_nmac"}, n_mac, (fl > 0 && on > 0) ? fl * on : 0);
    check_val({tag, "_maxidx"}, {28'd0, max_idx}, exp_idx);
    @(negedge clk);
    bus.acc_valid = 1'b1;
    bus.acc_data = 32'sh7fff_ffff;
    @(negedge clk);
    bus.acc_valid = 1'b0;
    #1;
    check_val({tag, "_hold_idx"}, {28'd0, max_idx}, exp_idx);
    check_val({tag, "_hold_done"}, {31'd0, fc_done}, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
    bus.acc_valid = 1'b0;
    bus.acc_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_all_zero("rst");
    rstn = 1'b1;
    clear_model();

    // Directed loads
    do_load(CmdLoadF, 4, -1, 0);
    do_load(CmdLoadW, 6, -1, 1);
    check_val("w_noerr", {31'd0, load_err}, 0);
    do_load(CmdLoadB, 5, 2, 2);
    check_val("b_outn", m_out_n, 12);

    // Directed compute: tie keeps lower index
    do_load(CmdLoadF, 3, -1, 0);
    do_load(CmdLoadB, 1, -1, 0);
    acc_tab[0] = 5; acc_tab[1] = -2; acc_tab[2] = 9; acc_tab[3] = 9;
    do_compute("cp_a");
    check_val("cp_a_idx", {28'd0, max_idx}, 2);
    acc_tab[0] = -7; acc_tab[1] = -3; acc_tab[2] = -3; acc_tab[3] = -10;
    do_compute("cp_b");
    check_val("cp_b_idx", {28'd0, max_idx}, 1);

    // Random load/compute rounds
    for (int it = 0; it < 6; it++) begin
      int bsz, tl;
      do_load(CmdLoadF, $urandom_range(1, 5), -1, 2);
      bsz = $urandom_range(0, 6);
      tl = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : -1;
      do_load(CmdLoadB, bsz, tl, 2);
      if ($urandom_range(0, 1) == 1) do_load(CmdLoadW, $urandom_range(1, 8), -1, 2);
      for (int r = 0; r < 16; r++) acc_tab[r] = $urandom_range(0, 40) - 20;
      do_compute("cp_rnd");
    end

    // Zero feature length
    do_load(CmdLoadF, 0, -1, 0);
    do_compute("cp_zero");
    check_val("cp_zero_idx", {28'd0, max_idx}, 0);

    // Reset in the middle of compute
    do_load(CmdLoadF, 3, -1, 0);
    do_load(CmdLoadB, 1, -1, 0);
    @(negedge clk);
    fc_start = 1'b1;
    @(negedge clk);
    fc_start = 1'b0;
    #1;
    check_val("mid_mac_en", {31'd0, bus.mac_en}, 1);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    clear_model();
    check_all_zero("mid_rst");
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.acc_valid = (k % 2 == 0);
      bus.acc_data = 100;
      #1;
      check_val("post_rst_mac", {31'd0, bus.mac_en}, 0);
    end
    bus.acc_valid = 1'b0;
    do_compute("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
